can_frame_rx: RTL and testbench
===============================

CAN_FRAME_RX -- requirements
Module: can_frame_rx

Interface
REQ-001 SHALL have parameter CONSEC, default 5: count of identical consecutive bits after which a stuff bit follows.
REQ-002 SHALL have parameter DEPTH, default 4: frame FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter CRC_POLY, default 15'h4599: CRC-15 generator polynomial, implicit x^15 term.
REQ-004 SHALL have a single clock and a synchronous, active-high reset: clk input, width 1, rising-edge clock; rst input, width 1.
REQ-005 SHALL have ports:
- bit_en, input, 1: one-cycle strobe at the bit sample point.
- rx, input, 1: bus level, 0 = dominant.
- en, input, 1: decoder enable.
- frame_ready, input, 1: consumer pop.
REQ-006 SHALL have outputs:
- frame_valid, 1: FIFO non-empty.
- frame_id, 11.
- frame_rtr, 1.
- frame_dlc, 4.
- frame_data, 64.
- fifo_count, $clog2(DEPTH)+1.
- overflow, 1: sticky.
- err_stuff, err_crc, err_form, 1 each: pulses.
- busy, 1: frame in progress.

Function
REQ-007 SHALL sample rx only on cycles with bit_en=1; all other cycles hold decoder state.
REQ-008 SHALL use states RESYNC, IDLE, ID, RTR, IDE, R0, DLC, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF.
REQ-009 RESYNC SHALL move to IDLE after 11 consecutive recessive bits; any dominant bit restarts that count.
REQ-010 IDLE SHALL treat a dominant bit as SOF, enter ID, and assert busy.
REQ-011 SHALL destuff from SOF through the last CRC bit: after CONSEC equal bits the next bit is discarded and is excluded from both the CRC and the field data.
REQ-012 A stuff bit equal to the preceding run SHALL pulse err_stuff for one cycle, discard the frame, and enter RESYNC.
REQ-013 ID field SHALL be 11 bits, MSB first.
REQ-014 IDE=1 (extended frame) SHALL pulse err_form and enter RESYNC.
REQ-015 DLC field SHALL be 4 bits; data byte count = min(DLC, 8); frame_dlc SHALL report the raw DLC value.
REQ-016 RTR=1 or byte count 0 SHALL skip DATA and go directly to CRC.
REQ-017 Data SHALL be received MSB first, byte 0 landing in frame_data[63:56]; unreceived bytes SHALL read zero.
REQ-018 CRC SHALL cover destuffed bits from SOF through the last data bit, with register init 0; the received 15-bit CRC SHALL be compared with the computed one.
REQ-019 CRC_DEL, ACK_DEL and all 7 EOF bits SHALL be recessive; any dominant bit there SHALL pulse err_form and enter RESYNC.
REQ-020 The ACK slot SHALL accept either level.
REQ-021 A CRC mismatch SHALL pulse err_crc on the cycle of the CRC_DEL bit_en; the frame is discarded and the decoder enters RESYNC.
REQ-022 A good frame SHALL be pushed on the 7th EOF bit_en; frame_valid SHALL rise on the next clk; the decoder then returns to IDLE with busy=0.
REQ-023 The FIFO SHALL be first-word-fall-through: frame_* show the head entry while frame_valid=1; frame_* are don't-care while frame_valid=0.
REQ-024 frame_valid and frame_ready both high SHALL pop one entry.
REQ-025 A push while full without a same-cycle pop SHALL drop the new frame, set overflow, and leave the FIFO unchanged.
REQ-026 A push and a pop in the same cycle while full SHALL accept both; fifo_count is unchanged.
REQ-027 A push and a pop in the same cycle while not full and not empty SHALL leave fifo_count unchanged.
REQ-028 fifo_count SHALL always equal the number of stored frames, range 0..DEPTH; pointers wrap modulo DEPTH.
REQ-029 overflow SHALL clear only on rst.
REQ-030 en=0 SHALL force the decoder to RESYNC on the next clk with no error pulse; the FIFO and the read port remain operational.

Reset
REQ-031 rst=1 at a clk edge SHALL:
- put the decoder in RESYNC with its bit counter at 0;
- empty the FIFO: fifo_count=0, frame_valid=0;
- clear overflow and busy;
- hold all error outputs at 0.
REQ-032 rst asserted mid-frame SHALL discard the partial frame with no push and no error pulse.

Verification
REQ-033 11 recessive bits, then a frame with ID 0x123, RTR 0, DLC 2, data A5 5A, valid CRC and EOF -> frame_valid=1 one clk after the 7th EOF bit_en; frame_id=0x123, frame_dlc=2, frame_data=64'hA55A000000000000, fifo_count=1.
REQ-034 Six dominant bits inside ID with no stuff bit -> one err_stuff pulse, fifo_count stays 0, decoder in RESYNC.
REQ-035 Same frame as REQ-033 with CRC LSB flipped -> one err_crc pulse at the CRC_DEL bit_en, no push.
REQ-036 DEPTH=4, five good frames with IDs 1..5 and frame_ready=0 -> fifo_count=4, overflow=1, head frame_id=1.
REQ-037 FIFO full, frame_ready=1 on the same clk as the push of ID 6 -> fifo_count=4, head frame_id=2, overflow unchanged.
REQ-038 rst pulsed during DATA of a frame -> busy=0, fifo_count=0, no error pulse; the next clean frame after 11 recessive bits is decoded correctly.

Source files
------------

// File: rtl/can_frame_rx.sv
// can_frame_rx: CAN 2.0A (standard 11-bit ID) frame receiver with bit
// destuffing, CRC-15 check, form checks and a first-word-fall-through
// frame FIFO.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   bit_en          one-cycle strobe at the bit sample point
//   rx              bus level (0 = dominant)
//   en              decoder enable; low forces the decoder to RESYNC
//   frame_ready     consumer pop (acts while frame_valid is high)
//   frame_valid     FIFO non-empty
//   frame_id/rtr/dlc/data  head entry of the FIFO
//   fifo_count      number of stored frames, 0..DEPTH
//   overflow        sticky: a good frame was dropped on a full FIFO
//   err_stuff/err_crc/err_form  one-cycle error pulses
//   busy            a frame is being received
module can_frame_rx #(
  parameter int unsigned CONSEC   = 5,
  parameter int unsigned DEPTH    = 4,
  parameter logic [14:0] CRC_POLY = 15'h4599
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_en,
  input  logic                     rx,
  input  logic                     en,
  input  logic                     frame_ready,
  output logic                     frame_valid,
  output logic [10:0]              frame_id,
  output logic                     frame_rtr,
  output logic [3:0]               frame_dlc,
  output logic [63:0]              frame_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     err_stuff,
  output logic                     err_crc,
  output logic                     err_form,
  output logic                     busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RUN_W = $clog2(CONSEC + 1);
  localparam int unsigned BIT_W = 6;

  typedef enum logic [3:0] {
    RESYNC, IDLE, ID, RTR, IDE, R0, DLC, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF
  } state_t;

  typedef struct packed {
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;

  // One CRC-15 step, MSB-first, implicit x^15 term.
  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic fb;
    fb = b ^ c[14];
    return {c[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'd0);
  endfunction

  // Payload byte count: DLC values above 8 still carry 8 bytes.
  function automatic logic [3:0] byte_cnt(input logic [3:0] d);
    return (d > 4'd8) ? 4'd8 : d;
  endfunction

  // Decoder state
  state_t             state_q, state_d;
  logic [BIT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [14:0]        crc_q, crc_d;
  logic [14:0]        rcrc_q, rcrc_d;
  logic [10:0]        id_q, id_d;
  logic               rtr_q, rtr_d;
  logic [3:0]         dlc_q, dlc_d;
  logic [63:0]        data_q, data_d;
  logic               err_stuff_q, err_stuff_d;
  logic               err_crc_q, err_crc_d;
  logic               err_form_q, err_form_d;
  logic               busy_q, busy_d;
  logic               push_c;

  // FIFO state
  frame_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               pop_c, full_c, push_ok_c;
  frame_t             frame_in_c, head_c;

  logic               stuffed_c;
  logic               stuff_due_c;
  logic [6:0]         data_bits_c;

  // Fields carried inside the stuffed region (SOF is handled from IDLE).
  assign stuffed_c   = state_q inside {ID, RTR, IDE, R0, DLC, DATA, CRC};
  // A stuff bit may also trail the last CRC bit, so CRC_DEL can owe one.
  assign stuff_due_c = (run_q == RUN_W'(CONSEC)) && (stuffed_c || state_q == CRC_DEL);
  assign data_bits_c = {byte_cnt(dlc_q), 3'b000};

  // Decoder next-state and field capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    run_d       = run_q;
    crc_d       = crc_q;
    rcrc_d      = rcrc_q;
    id_d        = id_q;
    rtr_d       = rtr_q;
    dlc_d       = dlc_q;
    data_d      = data_q;
    err_stuff_d = 1'b0;
    err_crc_d   = 1'b0;
    err_form_d  = 1'b0;
    push_c      = 1'b0;

    if (bit_en) begin
      if (stuff_due_c) begin
        // Stuff bit: must differ from the run, never enters CRC or fields.
        if (rx == last_q) begin
          err_stuff_d = 1'b1;
          state_d     = RESYNC;
          cnt_d       = '0;
        end else begin
          last_d = rx;
          run_d  = RUN_W'(1);
        end
      end else begin
        if (stuffed_c) begin
          last_d = rx;
          run_d  = (rx == last_q) ? run_q + RUN_W'(1) : RUN_W'(1);
          if (state_q != CRC) crc_d = crc_step(crc_q, rx);
        end

        unique case (state_q)
          RESYNC: begin
            if (!rx) begin
              cnt_d = '0;
            end else if (cnt_q == BIT_W'(10)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + BIT_W'(1);
            end
          end
          IDLE: begin
            if (!rx) begin
              state_d = ID;
              cnt_d   = '0;
              last_d  = 1'b0;
              run_d   = RUN_W'(1);
              crc_d   = crc_step(15'd0, 1'b0);
              rcrc_d  = '0;
              id_d    = '0;
              rtr_d   = 1'b0;
              dlc_d   = '0;
              data_d  = '0;
            end
          end
          ID: begin
            id_d = {id_q[9:0], rx};
            if (cnt_q == BIT_W'(10)) begin
              state_d = RTR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + BIT_W'(1);
            end
          end
          RTR: begin
            rtr_d   = rx;
            state_d = IDE;
          end
          IDE: begin
            if (rx) begin
              err_form_d = 1'b1;
              state_d    = RESYNC;
              cnt_d      = '0;
            end else begin
              state_d = R0;
            end
          end
          R0: begin
            state_d = DLC;
            cnt_d   = '0;
          end
          DLC: begin
            dlc_d = {dlc_q[2:0], rx};
            if (cnt_q == BIT_W'(3)) begin
              cnt_d   = '0;
              state_d = (rtr_q || byte_cnt({dlc_q[2:0], rx}) == 4'd0) ? CRC : DATA;
            end else begin
              cnt_d = cnt_q + BIT_W'(1);
            end
          end
          DATA: begin
            // MSB first; byte 0 lands in [63:56].
            data_d[BIT_W'(63) - cnt_q] = rx;
            if (cnt_q == BIT_W'(data_bits_c - 7'd1)) begin
              state_d = CRC;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + BIT_W'(1);
            end
          end
          CRC: begin
            rcrc_d = {rcrc_q[13:0], rx};
            if (cnt_q == BIT_W'(14)) begin
              state_d = CRC_DEL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + BIT_W'(1);
            end
          end
          CRC_DEL: begin
            if (rcrc_q != crc_q) begin
              err_crc_d = 1'b1;
              state_d   = RESYNC;
              cnt_d     = '0;
            end else if (!rx) begin
              err_form_d = 1'b1;
              state_d    = RESYNC;
              cnt_d      = '0;
            end else begin
              state_d = ACK;
            end
          end
          ACK: begin
            state_d = ACK_DEL;
          end
          ACK_DEL: begin
            if (!rx) begin
              err_form_d = 1'b1;
              state_d    = RESYNC;
              cnt_d      = '0;
            end else begin
              state_d = EOF;
              cnt_d   = '0;
            end
          end
          EOF: begin
            if (!rx) begin
              err_form_d = 1'b1;
              state_d    = RESYNC;
              cnt_d      = '0;
            end else if (cnt_q == BIT_W'(6)) begin
              push_c  = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + BIT_W'(1);
            end
          end
          default: begin
            state_d = RESYNC;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Disable silently abandons any frame in progress.
    if (!en) begin
      state_d     = RESYNC;
      cnt_d       = '0;
      err_stuff_d = 1'b0;
      err_crc_d   = 1'b0;
      err_form_d  = 1'b0;
      push_c      = 1'b0;
    end
  end

  assign busy_d = !(state_d inside {RESYNC, IDLE});

  // FIFO control: a full FIFO still accepts a push when the head pops.
  always_comb begin
    frame_in_c = {id_q, rtr_q, dlc_q, data_q};
    pop_c      = valid_q && frame_ready;
    full_c     = (count_q == CNT_W'(DEPTH));
    push_ok_c  = push_c && (!full_c || pop_c);
    ovf_d      = ovf_q | (push_c && full_c && !pop_c);
    wr_ptr_d   = push_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push_ok_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RESYNC;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      run_q       <= '0;
      crc_q       <= '0;
      rcrc_q      <= '0;
      id_q        <= '0;
      rtr_q       <= 1'b0;
      dlc_q       <= '0;
      data_q      <= '0;
      err_stuff_q <= 1'b0;
      err_crc_q   <= 1'b0;
      err_form_q  <= 1'b0;
      busy_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      run_q       <= run_d;
      crc_q       <= crc_d;
      rcrc_q      <= rcrc_d;
      id_q        <= id_d;
      rtr_q       <= rtr_d;
      dlc_q       <= dlc_d;
      data_q      <= data_d;
      err_stuff_q <= err_stuff_d;
      err_crc_q   <= err_crc_d;
      err_form_q  <= err_form_d;
      busy_q      <= busy_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
    end
  end

  // Frame storage, no reset needed (guarded by count/pointers)
  always_ff @(posedge clk) begin
    if (!rst && push_ok_c) mem_q[wr_ptr_q] <= frame_in_c;
  end

  assign head_c      = mem_q[rd_ptr_q];
  assign frame_valid = valid_q;
  assign frame_id    = head_c.id;
  assign frame_rtr   = head_c.rtr;
  assign frame_dlc   = head_c.dlc;
  assign frame_data  = head_c.data;
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;
  assign err_stuff   = err_stuff_q;
  assign err_crc     = err_crc_q;
  assign err_form    = err_form_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_can_frame_rx.sv
// Testbench for can_frame_rx: builds CAN frames as bit queues (field
// layout, CRC-15, bit stuffing), drives them with random bit spacing and
// compares every cycle against a queue-based model of the frame FIFO.
module tb_can_frame_rx;
  localparam int unsigned CONSEC = 5;
  localparam int unsigned DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst, bit_en, rx, en, frame_ready;
  logic        frame_valid, frame_rtr, overflow, err_stuff, err_crc, err_form, busy;
  logic [10:0] frame_id;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;
  logic [$clog2(DEPTH):0] fifo_count;

  can_frame_rx #(.CONSEC(CONSEC), .DEPTH(DEPTH), .CRC_POLY(15'h4599)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .rx(rx), .en(en), .frame_ready(frame_ready),
    .frame_valid(frame_valid), .frame_id(frame_id), .frame_rtr(frame_rtr),
    .frame_dlc(frame_dlc), .frame_data(frame_data), .fifo_count(fifo_count),
    .overflow(overflow), .err_stuff(err_stuff), .err_crc(err_crc), .err_form(err_form),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } tfr_t;

  int   total = 0;
  int   bad   = 0;
  bit   armed = 1'b0;

  // Reference model state
  tfr_t mq[$];
  bit   m_ovf, m_busy, m_pop;
  bit   [2:0] m_err;           // {stuff, crc, form}

  // What the driver announces for the bit on the wire this cycle
  bit   cur_push, cur_busy;
  bit   [2:0] cur_err;
  tfr_t cur_frame, nofr;
  bit   rand_ready = 1'b0;
  bit   ready_on_push = 1'b0;

  // Current stuffed frame on the wire
  bit   s[$];
  int   ide_pos, crcdel_pos;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] crc_upd(input logic [14:0] c, input bit b);
    logic [14:0] n;
    n = {c[13:0], 1'b0};
    if (b ^ c[14]) n = n ^ 15'h4599;
    return n;
  endfunction

  function automatic int nbytes(input tfr_t f);
    if (f.rtr) return 0;
    return (f.dlc > 4'd8) ? 8 : int'(f.dlc);
  endfunction

  function automatic tfr_t mk(input logic [10:0] id, input bit rtr, input logic [3:0] dlc,
                              input logic [63:0] d);
    tfr_t f;
    f.id = id; f.rtr = rtr; f.dlc = dlc; f.data = 64'd0;
    for (int b = 0; b < nbytes(f); b++) f.data[63 - 8*b -: 8] = d[63 - 8*b -: 8];
    return f;
  endfunction

  // Model: FIFO as a queue, errors/busy as announced by the driver.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete(); m_ovf = 1'b0; m_busy = 1'b0; m_err = 3'b000;
    end else begin
      m_pop = frame_ready && (mq.size() > 0);
      if (m_pop) void'(mq.pop_front());
      m_err = 3'b000;
      if (!en) begin
        m_busy = 1'b0;
      end else if (bit_en) begin
        m_err  = cur_err;
        m_busy = cur_busy;
        if (cur_push) begin
          if (mq.size() < DEPTH) mq.push_back(cur_frame);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("frame_valid", 64'(frame_valid), 64'(mq.size() != 0));
      chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("err_stuff", 64'(err_stuff), 64'(m_err[2]));
      chk("err_crc", 64'(err_crc), 64'(m_err[1]));
      chk("err_form", 64'(err_form), 64'(m_err[0]));
      if (mq.size() > 0) begin
        chk("frame_id", 64'(frame_id), 64'(mq[0].id));
        chk("frame_rtr", 64'(frame_rtr), 64'(mq[0].rtr));
        chk("frame_dlc", 64'(frame_dlc), 64'(mq[0].dlc));
        chk("frame_data", frame_data, mq[0].data);
      end
    end
  end

  // Drive one bus bit (called at a negedge), then 0..2 idle cycles.
  task automatic send_bit(input bit b, input bit busy_after, input bit push,
                          input bit [2:0] err, input tfr_t f);
    int gap;
    rx = b; bit_en = 1'b1;
    cur_busy = busy_after; cur_push = push; cur_err = err; cur_frame = f;
    frame_ready = (ready_on_push && push) ? 1'b1 :
                  (rand_ready ? ($urandom_range(0, 3) == 0) : 1'b0);
    @(negedge clk);
    bit_en = 1'b0; cur_push = 1'b0; cur_err = 3'b000;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      rx = 1'($urandom_range(0, 1));
      frame_ready = rand_ready ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n) send_bit(1'b1, 1'b0, 1'b0, 3'b000, nofr);
  endtask

  // Lay out the frame, compute CRC, stuff SOF..CRC, append the tail.
  task automatic build(input tfr_t f, input bit ide, input bit flip_crc, input bit ack);
    bit raw[$];
    logic [14:0] crc;
    bit last;
    int run;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(f.id[i]);
    raw.push_back(f.rtr);
    raw.push_back(ide);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(f.dlc[i]);
    for (int i = 0; i < 8 * nbytes(f); i++) raw.push_back(f.data[63 - i]);
    crc = 15'd0;
    foreach (raw[i]) crc = crc_upd(crc, raw[i]);
    if (flip_crc) crc[0] = ~crc[0];
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    s.delete();
    last = 1'b0; run = 0;
    foreach (raw[i]) begin
      s.push_back(raw[i]);
      if (i == 13) ide_pos = s.size() - 1;
      if (i > 0 && raw[i] == last) run++;
      else run = 1;
      last = raw[i];
      if (run == CONSEC) begin
        s.push_back(!last);
        last = !last;
        run = 1;
      end
    end
    crcdel_pos = s.size();
    s.push_back(1'b1);
    s.push_back(ack);
    s.push_back(1'b1);
    repeat (7) s.push_back(1'b1);
  endtask

  // mode: 0 good, 1 bad CRC, 2 IDE=1, 3 dominant EOF bit, 4 en drop, 5 rst
  task automatic send_frame(input tfr_t f, input int mode);
    int cut, last;
    bit [2:0] e;
    idle_bits(11 + $urandom_range(0, 2));
    build(f, mode == 2, mode == 1, 1'($urandom_range(0, 1)));
    last = s.size() - 1;
    case (mode)
      1: cut = crcdel_pos;
      2: cut = ide_pos;
      3: cut = s.size() - 7 + $urandom_range(0, 6);
      4, 5: cut = $urandom_range(ide_pos + 7, crcdel_pos - 2);
      default: cut = last;
    endcase
    if (mode == 3) s[cut] = 1'b0;
    for (int i = 0; i <= cut; i++) begin
      if (i == cut && mode == 4) begin
        en = 1'b0; @(negedge clk); en = 1'b1;
      end else if (i == cut && mode == 5) begin
        rst = 1'b1; @(negedge clk); rst = 1'b0;
      end else begin
        e = 3'b000;
        if (i == cut && mode == 1) e = 3'b010;
        if (i == cut && (mode == 2 || mode == 3)) e = 3'b001;
        send_bit(s[i], i < cut, mode == 0 && i == last, e, f);
      end
    end
  endtask

  task automatic pop_all();
    frame_ready = 1'b1;
    repeat (DEPTH + 1) @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    tfr_t f;
    int r;
    nofr = mk(11'd0, 1'b0, 4'd0, 64'd0);
    rst = 1'b1; bit_en = 1'b0; rx = 1'b1; en = 1'b1; frame_ready = 1'b0;
    cur_push = 1'b0; cur_busy = 1'b0; cur_err = 3'b000; cur_frame = nofr;
    repeat (3) @(negedge clk);
    armed = 1'b1;
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_errs", 64'({err_stuff, err_crc, err_form}), 64'd0);
    rst = 1'b0;

    // Reference frame: ID 0x123, DLC 2, data A5 5A
    f = mk(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000);
    send_frame(f, 0);
    chk("ref_valid", 64'(frame_valid), 64'd1);
    chk("ref_id", 64'(frame_id), 64'h123);
    chk("ref_dlc", 64'(frame_dlc), 64'd2);
    chk("ref_data", frame_data, 64'hA55A_0000_0000_0000);
    chk("ref_count", 64'(fifo_count), 64'd1);
    pop_all();

    // Six dominant bits from SOF into ID without a stuff bit
    idle_bits(11);
    repeat (5) send_bit(1'b0, 1'b1, 1'b0, 3'b000, nofr);
    send_bit(1'b0, 1'b0, 1'b0, 3'b100, nofr);
    send_bit(1'b0, 1'b0, 1'b0, 3'b000, nofr);
    chk("stuff_count", 64'(fifo_count), 64'd0);
    chk("stuff_busy", 64'(busy), 64'd0);

    // Same reference frame with the CRC LSB flipped
    send_frame(f, 1);
    chk("crc_count", 64'(fifo_count), 64'd0);

    // Five frames into a 4-deep FIFO with no consumer
    for (int k = 1; k <= 5; k++) send_frame(mk(11'(k), 1'b0, 4'd1, 64'(k) << 56), 0);
    chk("ovf_count", 64'(fifo_count), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_head", 64'(frame_id), 64'd1);

    // Push of ID 6 on a full FIFO with a same-cycle pop
    ready_on_push = 1'b1;
    send_frame(mk(11'd6, 1'b0, 4'd0, 64'd0), 0);
    ready_on_push = 1'b0;
    chk("pp_count", 64'(fifo_count), 64'd4);
    chk("pp_head", 64'(frame_id), 64'd2);
    chk("pp_ovf", 64'(overflow), 64'd1);
    pop_all();

    // Reset in the middle of a data field, then a clean frame
    send_frame(mk(11'h2AA, 1'b0, 4'd8, 64'hDEAD_BEEF_0123_4567), 5);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_count", 64'(fifo_count), 64'd0);
    chk("rstmid_ovf", 64'(overflow), 64'd0);
    send_frame(mk(11'h7F0, 1'b0, 4'd3, 64'h0F1E_2D00_0000_0000), 0);
    chk("after_rst_id", 64'(frame_id), 64'h7F0);
    chk("after_rst_data", frame_data, 64'h0F1E_2D00_0000_0000);
    pop_all();

    // Randomized frames, modes and consumer behaviour
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      f = mk(11'($urandom), $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
             {$urandom, $urandom});
      r = $urandom_range(0, 9);
      send_frame(f, (r < 5) ? 0 : (r - 4));
    end
    rand_ready = 1'b0;
    frame_ready = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
